fft_avalon_dma_master: RTL and testbench
========================================

Name: fft_avalon_dma_master

Overview:
Parametrised Avalon-MM master that moves one FFT frame between system memory and the FFT core.
- On start, it reads NUM_SAMPLES words from a read base address and streams them into the FFT sample buffer.
- It then pulses fft_start, waits for fft_done, and writes NUM_SAMPLES result words back to a write base address.
- Generalises the earlier fixed 16-bit / 512-point master to configurable data width, address width and frame length, and adds error reporting and abort.

Parameters:
- DATA_W, 16, sample and bus data width in bits; multiple of 8.
- ADDR_W, 32, Avalon byte-address width.
- NUM_SAMPLES, 512, words per frame; must be at least 2.
- IDX_W, $clog2(NUM_SAMPLES), sample-index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a frame; ignored unless in IDLE or ERROR.
- abort  in  1  return to IDLE at the next safe point.
- rd_base  in  ADDR_W  source byte address; latched on start.
- wr_base  in  ADDR_W  destination byte address; latched on start.
- master_read  out  1  Avalon read command.
- master_write  out  1  Avalon write command.
- master_address  out  ADDR_W  Avalon byte address.
- master_write_data  out  DATA_W  Avalon write data.
- master_waitrequest  in  1  slave stall.
- master_readdata  in  DATA_W  read data.
- master_readdatavalid  in  1  read data valid.
- master_response  in  2  response code; 00 = OKAY.
- sample_valid  out  1  one-cycle write strobe into the FFT sample buffer.
- sample_index  out  IDX_W  sample buffer index.
- sample_data  out  DATA_W  sample value.
- fft_start  out  1  one-cycle pulse to the FFT core.
- fft_done  in  1  FFT completion pulse.
- res_rd_en  out  1  result buffer read strobe; data is returned one cycle later.
- res_index  out  IDX_W  result buffer index.
- res_data  in  DATA_W  result word, valid the cycle after res_rd_en.
- busy  out  1  high in every state except IDLE and ERROR.
- done  out  1  one-cycle frame-complete pulse.
- error  out  1  sticky error flag; cleared by start or rst.

Behaviour:
- Reset state: rst asynchronously forces state to IDLE and clears idx, every output, and the latched base addresses.
- Address alignment: address = base + idx*(DATA_W/8). The low log2(DATA_W/8) bits of each base are forced to zero when latched.
- IDLE:
  - start → latch both bases, idx=0, clear error, go to RD_REQ.
- RD_REQ:
  - master_read=1, master_address = read address.
  - Command and address are held stable while master_waitrequest=1.
  - First cycle with waitrequest=0 accepts the command; master_read drops the next cycle and the state moves to RD_WAIT.
  - Only one read is outstanding at a time.
- RD_WAIT: wait for master_readdatavalid. When it is high:
  - If master_response != 00 → ERROR.
  - Otherwise, the next cycle drives sample_valid=1, sample_index=idx, sample_data=readdata.
  - If idx == NUM_SAMPLES-1 → WAIT_FFT; otherwise idx+1 → RD_REQ.
- WAIT_FFT:
  - fft_start pulses on the first cycle in this state.
  - fft_done (any cycle, including the fft_start cycle) → idx=0, WR_FETCH.
- WR_FETCH:
  - res_rd_en=1, res_index=idx for exactly one cycle, then WR_REQ.
  - res_data is captured into the write-data register on entry to WR_REQ.
- WR_REQ:
  - master_write=1, address = write address, write data = captured word.
  - Held stable while waitrequest=1.
  - On acceptance: if idx == NUM_SAMPLES-1 → DONE; otherwise idx+1 → WR_FETCH.
- DONE: done=1 for one cycle, then IDLE.
- ERROR:
  - error=1 and busy=0; no bus activity.
  - start restarts the frame exactly as from IDLE.
- Read-to-write turnaround: minimum per-word throughput is 3 cycles per read (zero wait states, readdatavalid the cycle after accept) and 2 cycles per write.
- abort:
  - Sampled every cycle.
  - If a command is asserted and waitrequest=1, abort is deferred until acceptance; a pending read also waits for its readdatavalid.
  - Then go to IDLE with no done pulse and error unchanged.
- Simultaneous start+abort in IDLE: abort wins.
- start while busy is ignored.
- Simultaneous readdatavalid with error response and abort: ERROR wins.
- idx never wraps; the terminal compare is always against NUM_SAMPLES-1.

Optional Feature:
AVM_STALL_CNT_EN.
- Defined: adds output stall_cycles [31:0].
  - Counts cycles where (master_read|master_write)&master_waitrequest.
  - Cleared when start is accepted; saturates at 0xFFFFFFFF; holds its value in IDLE, DONE and ERROR.
- Undefined: no port and no counter logic.

Test Plan:
- Normal frame, DATA_W=16, NUM_SAMPLES=4, rd_base=0x1000, wr_base=0x2001, zero wait states, memory 0x1111..0x4444:
  - Expected: reads at 0x1000/02/04/06; sample_index 0..3 with those values; one fft_start pulse.
  - After fft_done with res_data=idx+0xA0: writes to 0x2000/02/04/06 with data 0xA0..0xA3; one done pulse; busy low afterwards.
- Waitrequest held 3 cycles on the second read and 2 cycles on the third write:
  - Expected: address and data stable throughout each stall; frame completes correctly.
  - With AVM_STALL_CNT_EN defined: stall_cycles=5.
- master_response=10 on the third readdatavalid:
  - Expected: ERROR state, error=1, busy=0; only 2 sample_valid strobes; no fft_start.
  - A following start clears error and the frame runs to completion.
- abort asserted while the first write is stalled by waitrequest:
  - Expected: write stays asserted until accepted; next cycle IDLE; no done pulse; no further writes.
- rst asserted mid-read, while master_read=1:
  - Expected: all outputs 0 immediately (asynchronous).
  - After release: no bus activity until start.
- start pulsed during WAIT_FFT:
  - Expected: ignored; bases unchanged; frame finishes with the original addresses.

Source files
------------

// File: rtl/fft_avalon_dma_master.sv
// fft_avalon_dma_master
//   Avalon-MM master that moves one FFT frame: reads NUM_SAMPLES words from
//   rd_base into the FFT sample buffer, pulses fft_start, waits for fft_done,
//   then copies NUM_SAMPLES result words from the result buffer to wr_base.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             frame request / return to IDLE at a safe point
//   rd_base, wr_base         byte base addresses, latched on start
//   master_*                 Avalon-MM master (one outstanding read)
//   sample_valid/index/data  write port into the FFT sample buffer
//   fft_start, fft_done      FFT core handshake
//   res_rd_en/index, res_data result buffer read port (1-cycle latency)
//   busy, done, error        status (error is sticky until start or rst)
//
// Optional build macro
//   AVM_STALL_CNT_EN  adds stall_cycles[31:0], a saturating count of cycles
//                     in which an asserted command was stalled by waitrequest.
module fft_avalon_dma_master #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int NUM_SAMPLES = 512,
  parameter int IDX_W       = $clog2(NUM_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              master_read,
  output logic              master_write,
  output logic [ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0] master_write_data,
  input  logic              master_waitrequest,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  input  logic [1:0]        master_response,
  output logic              sample_valid,
  output logic [IDX_W-1:0]  sample_index,
  output logic [DATA_W-1:0] sample_data,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              res_rd_en,
  output logic [IDX_W-1:0]  res_index,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef AVM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int AL_W  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << AL_W) - ADDR_W'(1));
  localparam logic [IDX_W-1:0]  LAST       = IDX_W'(NUM_SAMPLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_PUSH, S_WAIT_FFT,
    S_WR_FETCH, S_WR_REQ, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic              error_q, error_d;
  logic              abort_pend_q, abort_pend_d;
  logic              fft_start_q, fft_start_d;
  logic              wr_first_q, wr_first_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic              abort_req, start_ok;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign abort_req = abort | abort_pend_q;
  // Abort beats a simultaneous start.
  assign start_ok  = start & ~abort;
  assign rd_addr   = rd_base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);
  assign wr_addr   = wr_base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_ok) begin
          rd_base_d = rd_base & ALIGN_MASK;
          wr_base_d = wr_base & ALIGN_MASK;
          idx_d     = '0;
          error_d   = 1'b0;
          state_d   = S_RD_REQ;
        end
      end
      // An accepted read cannot be retracted, so abort waits for its data.
      S_RD_REQ:  if (!master_waitrequest) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (master_readdatavalid) begin
          if (master_response != 2'b00) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (abort_req) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_PUSH;
          end
        end
      end
      S_RD_PUSH: begin
        if (abort_req)          state_d = S_IDLE;
        else if (idx_q == LAST) state_d = S_WAIT_FFT;
        else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD_REQ;
        end
      end
      S_WAIT_FFT: begin
        if (abort_req) state_d = S_IDLE;
        else if (fft_done) begin
          idx_d   = '0;
          state_d = S_WR_FETCH;
        end
      end
      S_WR_FETCH: state_d = abort_req ? S_IDLE : S_WR_REQ;
      S_WR_REQ: begin
        if (!master_waitrequest) begin
          if (abort_req)          state_d = S_IDLE;
          else if (idx_q == LAST) state_d = S_DONE;
          else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_WR_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A deferred abort is remembered until the machine comes to rest.
    abort_pend_d = ((state_d == S_IDLE) || (state_d == S_ERROR)) ? 1'b0 : abort_req;
    fft_start_d  = (state_d == S_WAIT_FFT) && (state_q != S_WAIT_FFT);
    wr_first_d   = (state_d == S_WR_REQ) && (state_q != S_WR_REQ);
    rdata_d      = (state_q == S_RD_WAIT && master_readdatavalid) ? master_readdata : rdata_q;
    // res_data is valid during the first WR_REQ cycle; hold it for any stall.
    wdata_d      = (state_q == S_WR_REQ && wr_first_q) ? res_data : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      error_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      fft_start_q  <= 1'b0;
      wr_first_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_base_q    <= rd_base_d;
      wr_base_q    <= wr_base_d;
      error_q      <= error_d;
      abort_pend_q <= abort_pend_d;
      fft_start_q  <= fft_start_d;
      wr_first_q   <= wr_first_d;
    end
  end

  // Data holding registers; every output that uses them is gated by state.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    master_read       = (state_q == S_RD_REQ);
    master_write      = (state_q == S_WR_REQ);
    master_address    = master_read ? rd_addr : (master_write ? wr_addr : '0);
    master_write_data = master_write ? (wr_first_q ? res_data : wdata_q) : '0;
    sample_valid      = (state_q == S_RD_PUSH);
    sample_index      = sample_valid ? idx_q : '0;
    sample_data       = sample_valid ? rdata_q : '0;
    fft_start         = fft_start_q;
    res_rd_en         = (state_q == S_WR_FETCH);
    res_index         = res_rd_en ? idx_q : '0;
    busy              = (state_q != S_IDLE) && (state_q != S_ERROR);
    done              = (state_q == S_DONE);
    error             = error_q;
  end

`ifdef AVM_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (((state_q == S_IDLE) || (state_q == S_ERROR)) && start_ok)
      stall_d = '0;
    else if ((master_read | master_write) && master_waitrequest && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fft_avalon_dma_master.sv
module tb_fft_avalon_dma_master;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 32;
  localparam int NUM_SAMPLES = 4;
  localparam int IDX_W       = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, abort;
  logic [ADDR_W-1:0] rd_base, wr_base;
  logic              master_read, master_write;
  logic [ADDR_W-1:0] master_address;
  logic [DATA_W-1:0] master_write_data;
  logic              master_waitrequest;
  logic [DATA_W-1:0] master_readdata;
  logic              master_readdatavalid;
  logic [1:0]        master_response;
  logic              sample_valid;
  logic [IDX_W-1:0]  sample_index;
  logic [DATA_W-1:0] sample_data;
  logic              fft_start, fft_done;
  logic              res_rd_en;
  logic [IDX_W-1:0]  res_index;
  logic [DATA_W-1:0] res_data;
  logic              busy, done, error;
`ifdef AVM_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  fft_avalon_dma_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SAMPLES(NUM_SAMPLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_base(rd_base), .wr_base(wr_base),
    .master_read(master_read), .master_write(master_write),
    .master_address(master_address), .master_write_data(master_write_data),
    .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid), .master_response(master_response),
    .sample_valid(sample_valid), .sample_index(sample_index), .sample_data(sample_data),
    .fft_start(fft_start), .fft_done(fft_done),
    .res_rd_en(res_rd_en), .res_index(res_index), .res_data(res_data),
    .busy(busy), .done(done), .error(error)
`ifdef AVM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- slave / FFT core / result buffer model ----------------
  int stall_rd, stall_rd_len, stall_wr, stall_wr_len, err_rd, fft_lat;
  int rd_acc, wr_acc, rd_stc, wr_stc, fft_cnt;

  assign master_waitrequest =
      (master_read  && (rd_acc == stall_rd) && (rd_stc < stall_rd_len)) ||
      (master_write && (wr_acc == stall_wr) && (wr_stc < stall_wr_len));

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] k;
    k = ((a - 32'h1000) >> 1) + 32'd1;
    return DATA_W'(k * 32'h1111);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_acc <= 0; wr_acc <= 0; rd_stc <= 0; wr_stc <= 0; fft_cnt <= 0;
      master_readdatavalid <= 1'b0; master_readdata <= '0; master_response <= 2'b00;
      fft_done <= 1'b0; res_data <= '0;
    end else begin
      master_readdatavalid <= 1'b0;
      fft_done <= 1'b0;
      if (start) begin
        rd_acc <= 0; wr_acc <= 0; rd_stc <= 0; wr_stc <= 0;
      end else begin
        if (master_read && master_waitrequest) rd_stc <= rd_stc + 1;
        if (master_read && !master_waitrequest) begin
          rd_acc <= rd_acc + 1;
          rd_stc <= 0;
          master_readdatavalid <= 1'b1;
          master_readdata <= mem_word(master_address);
          master_response <= (rd_acc == err_rd) ? 2'b10 : 2'b00;
        end
        if (master_write && master_waitrequest) wr_stc <= wr_stc + 1;
        if (master_write && !master_waitrequest) begin
          wr_acc <= wr_acc + 1;
          wr_stc <= 0;
        end
      end
      if (res_rd_en) res_data <= DATA_W'(res_index) + 16'h00A0;
      if (fft_start) fft_cnt <= fft_lat;
      else if (fft_cnt > 0) begin
        fft_cnt <= fft_cnt - 1;
        if (fft_cnt == 1) fft_done <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic busy; logic err; logic zero; logic tmo; logic chk_st; logic [31:0] stalls;
    int rd_n; int samp_n; int wr_n; int fft_tot; int done_tot;
  } st_t;
  typedef struct { logic [IDX_W-1:0] idx; logic [DATA_W-1:0] data; } smp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;

  logic [ADDR_W-1:0] exp_rd[$];
  smp_t              exp_smp[$];
  wr_t               exp_wr[$];
  st_t               exp_st[$];

  int n_checks = 0, n_fail = 0;
  int rd_ptr = 0, smp_ptr = 0, wr_ptr = 0, st_ptr = 0;
  int fft_seen = 0, done_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    st_t s;
    logic outs_any;
    if (st_ptr < exp_st.size()) begin
      s = exp_st[st_ptr];
      st_ptr++;
      chk("wait_bound", 64'(s.tmo), 64'd0);
      chk("busy", 64'(busy), 64'(s.busy));
      chk("error", 64'(error), 64'(s.err));
      chk("fft_start_count", 64'(fft_seen), 64'(s.fft_tot));
      chk("done_count", 64'(done_seen), 64'(s.done_tot));
      if (s.zero) begin
        outs_any = |{master_read, master_write, master_address, master_write_data,
                     sample_valid, sample_index, sample_data, fft_start, res_rd_en,
                     res_index, busy, done, error};
        chk("reset_outputs", 64'(outs_any), 64'd0);
      end else begin
        chk("read_count", 64'(rd_ptr), 64'(s.rd_n));
        chk("sample_count", 64'(smp_ptr), 64'(s.samp_n));
        chk("write_count", 64'(wr_ptr), 64'(s.wr_n));
      end
`ifdef AVM_STALL_CNT_EN
      if (s.chk_st) chk("stall_cycles", 64'(stall_cycles), 64'(s.stalls));
`endif
    end
    if (rst) begin
      rd_ptr = exp_rd.size(); smp_ptr = exp_smp.size(); wr_ptr = exp_wr.size();
    end else begin
      if (fft_start) fft_seen++;
      if (done) done_seen++;
      if (master_read) begin
        if (rd_ptr < exp_rd.size()) begin
          chk("rd_addr", 64'(master_address), 64'(exp_rd[rd_ptr]));
          if (!master_waitrequest) rd_ptr++;
        end else chk("read_count", 64'(rd_ptr + 1), 64'(exp_rd.size()));
      end
      if (sample_valid) begin
        if (smp_ptr < exp_smp.size()) begin
          chk("sample_index", 64'(sample_index), 64'(exp_smp[smp_ptr].idx));
          chk("sample_data", 64'(sample_data), 64'(exp_smp[smp_ptr].data));
          smp_ptr++;
        end else chk("sample_count", 64'(smp_ptr + 1), 64'(exp_smp.size()));
      end
      if (master_write) begin
        if (wr_ptr < exp_wr.size()) begin
          chk("wr_addr", 64'(master_address), 64'(exp_wr[wr_ptr].addr));
          chk("wr_data", 64'(master_write_data), 64'(exp_wr[wr_ptr].data));
          if (!master_waitrequest) wr_ptr++;
        end else chk("write_count", 64'(wr_ptr + 1), 64'(exp_wr.size()));
      end
    end
  end

  // ---------------- stimulus ----------------
  int fft_tot = 0, done_tot = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_state(input logic b, input logic e, input logic z, input logic t,
                            input logic cs, input logic [31:0] st);
    st_t s;
    s.busy = b; s.err = e; s.zero = z; s.tmo = t; s.chk_st = cs; s.stalls = st;
    s.rd_n = exp_rd.size(); s.samp_n = exp_smp.size(); s.wr_n = exp_wr.size();
    s.fft_tot = fft_tot; s.done_tot = done_tot;
    exp_st.push_back(s);
  endtask

  task automatic frame_expect(input int n_rd, input int n_smp, input int n_wr);
    smp_t sm;
    wr_t  w;
    for (int k = 0; k < n_rd; k++) exp_rd.push_back(32'h1000 + 32'(2 * k));
    for (int k = 0; k < n_smp; k++) begin
      sm.idx = IDX_W'(k); sm.data = DATA_W'(32'h1111 * (k + 1));
      exp_smp.push_back(sm);
    end
    for (int k = 0; k < n_wr; k++) begin
      w.addr = 32'h2000 + 32'(2 * k); w.data = DATA_W'(16'h00A0 + k);
      exp_wr.push_back(w);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] wb);
    start = 1'b1; rd_base = rb; wr_base = wb;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output logic to);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    to = busy;
  endtask

  initial begin
    logic to;
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_base = '0; wr_base = '0;
    stall_rd = -1; stall_rd_len = 0; stall_wr = -1; stall_wr_len = 0;
    err_rd = -1; fft_lat = 3;
    repeat (3) tick();
    push_state(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Normal frame, zero wait states.
    frame_expect(4, 4, 4);
    fft_tot++; done_tot++;
    do_start(32'h1000, 32'h2001);
    wait_idle(200, to);
    push_state(1'b0, 1'b0, 1'b0, to, 1'b0, 32'd0);
    tick();

    // Stalls: 3 cycles on second read, 2 on third write.
    stall_rd = 1; stall_rd_len = 3; stall_wr = 2; stall_wr_len = 2;
    frame_expect(4, 4, 4);
    fft_tot++; done_tot++;
    do_start(32'h1000, 32'h2001);
    wait_idle(200, to);
    push_state(1'b0, 1'b0, 1'b0, to, 1'b1, 32'd5);
    tick();
    stall_rd = -1; stall_wr = -1;

    // Error response on third read, then a clean restart.
    err_rd = 2;
    frame_expect(3, 2, 0);
    do_start(32'h1000, 32'h2001);
    wait_idle(200, to);
    push_state(1'b0, 1'b1, 1'b0, to, 1'b0, 32'd0);
    tick();
    err_rd = -1;
    frame_expect(4, 4, 4);
    fft_tot++; done_tot++;
    do_start(32'h1000, 32'h2001);
    wait_idle(200, to);
    push_state(1'b0, 1'b0, 1'b0, to, 1'b0, 32'd0);
    tick();

    // Abort while the first write is stalled.
    stall_wr = 0; stall_wr_len = 4;
    frame_expect(4, 4, 1);
    fft_tot++;
    do_start(32'h1000, 32'h2001);
    n = 0;
    while (!(master_write && master_waitrequest) && n < 200) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(200, to);
    repeat (8) tick();
    push_state(1'b0, 1'b0, 1'b0, to || (n >= 200), 1'b0, 32'd0);
    tick();
    stall_wr = -1;

    // Asynchronous reset while a read is being stalled.
    stall_rd = 0; stall_rd_len = 3;
    frame_expect(4, 4, 4);
    do_start(32'h1000, 32'h2001);
    n = 0;
    while (!master_read && n < 50) begin
      tick();
      n++;
    end
    rst = 1'b1;
    push_state(1'b0, 1'b0, 1'b1, n >= 50, 1'b0, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    stall_rd = -1;
    repeat (10) tick();
    push_state(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // start during WAIT_FFT is ignored.
    fft_lat = 8;
    frame_expect(4, 4, 4);
    fft_tot++; done_tot++;
    do_start(32'h1000, 32'h2001);
    n = 0;
    while (!fft_start && n < 200) begin
      tick();
      n++;
    end
    tick();
    do_start(32'h5000, 32'h6000);
    wait_idle(200, to);
    push_state(1'b0, 1'b0, 1'b0, to || (n >= 200), 1'b0, 32'd0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
